// File: rtl/waveform_capture.sv
`timescale 1ns/1ps
// waveform_capture: receive-side partner of the pmod AWG. Samples an 8-bit
// bus on a divided tick, waits for a level-crossing trigger, stores DEPTH
// samples, measures the waveform period in samples and streams the buffer
// out over a valid/ready port.
module waveform_capture #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 128,
  parameter int SAMPLE_DIV   = 1,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    ref_clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic                    arm,
  input  logic [DATA_WIDTH-1:0]   trig_level,
  input  logic                    trig_rising,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  // Input synchronizer and sample-rate divider
  logic [DATA_WIDTH-1:0]   r_sync1;
  logic [DATA_WIDTH-1:0]   r_sync2;
  logic [DIV_W-1:0]        r_div;
  logic                    w_tick;

  // Trigger configuration and crossing detector
  logic [DATA_WIDTH-1:0]   r_level;
  logic                    r_rising;
  logic [DATA_WIDTH-1:0]   r_prev;
  logic                    r_prev_ok;
  logic                    w_cross;

  // Capture buffer and pointers
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_mem_q;
  logic [ADDR_W-1:0]       r_wr_ptr;
  logic [ADDR_W-1:0]       r_rd_ptr;
  logic [ADDR_W-1:0]       w_wr_addr;
  logic [ADDR_W-1:0]       w_rd_addr;

  // Period measurement
  logic [PERIOD_WIDTH-1:0] r_cnt;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic                    r_period_valid;

  // Readout handshake
  logic                    r_rd_valid;
  logic                    r_done;
  logic                    w_xfer;
  logic                    w_last;

  // FSM strobes
  logic                    w_arm_accept;
  logic                    w_trigger;
  logic                    w_wr_en;
  logic                    w_capture_end;
  logic                    w_cap_tick;

  assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

  // Crossing compares the newest synchronized sample against the previous ticked one.
  assign w_cross = r_rising ? ((r_prev <  r_level) && (r_sync2 >= r_level))
                            : ((r_prev >= r_level) && (r_sync2 <  r_level));

  assign w_last     = r_rd_valid && (r_rd_ptr == ADDR_W'(DEPTH - 1));
  assign w_xfer     = r_rd_valid && rd_ready;
  assign w_cap_tick = (r_state == S_CAPTURE) && w_tick;
  assign w_wr_addr  = w_trigger ? '0 : r_wr_ptr;
  // Read the next word as soon as the current one is taken so data is ready back-to-back.
  assign w_rd_addr  = w_xfer ? (r_rd_ptr + 1'b1) : r_rd_ptr;

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign rd_valid     = r_rd_valid;
  assign rd_last      = w_last;
  assign rd_data      = r_rd_valid ? r_mem_q : '0;
  assign period       = r_period;
  assign period_valid = r_period_valid;

  // State register
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    w_state_next  = r_state;
    w_arm_accept  = 1'b0;
    w_trigger     = 1'b0;
    w_wr_en       = 1'b0;
    w_capture_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_arm_accept = 1'b1;
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        // The first tick after arming only primes r_prev.
        if (w_tick && r_prev_ok && w_cross) begin
          w_trigger    = 1'b1;
          w_wr_en      = 1'b1;
          w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (w_tick) begin
          w_wr_en = 1'b1;
          if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
            w_capture_end = 1'b1;
            w_state_next  = S_READOUT;
          end
        end
      end
      S_READOUT: begin
        if (w_xfer && w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Two-flop synchronizer on the asynchronous sample bus
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sample_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample divider, independent of FSM state
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Trigger settings latched on arm; previous-sample history for crossing detection
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      r_level   <= '0;
      r_rising  <= 1'b1;
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
    end else begin
      if (w_arm_accept) begin
        r_level   <= trig_level;
        r_rising  <= trig_rising;
        r_prev_ok <= 1'b0;
      end else if (w_tick && ((r_state == S_ARMED) || (r_state == S_CAPTURE))) begin
        r_prev    <= r_sync2;
        r_prev_ok <= 1'b1;
      end
    end
  end

  // Capture buffer: synchronous write, registered read (block RAM friendly, no reset)
  always_ff @(posedge ref_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= r_sync2;
    end
    r_mem_q <= r_mem[w_rd_addr];
  end

  // Write and read pointers
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_trigger) begin
        r_wr_ptr <= ADDR_W'(1);
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_arm_accept || w_capture_end) begin
        r_rd_ptr <= '0;
      end else if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Period counter: counts capture ticks since the trigger and latches on the next same-polarity crossing
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      if (w_arm_accept) begin
        r_period       <= '0;
        r_period_valid <= 1'b0;
      end else if (w_cap_tick && w_cross && !r_period_valid) begin
        r_period       <= r_cnt;
        r_period_valid <= 1'b1;
      end
      if (w_trigger) begin
        r_cnt <= PERIOD_WIDTH'(1);
      end else if (w_cap_tick && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Readout valid trails READOUT entry by one cycle to cover the RAM read; done follows the last transfer
  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == S_READOUT) && !(w_xfer && w_last);
      r_done     <= (r_state == S_READOUT) && w_xfer && w_last;
    end
  end

endmodule

// File: tb/tb_waveform_capture.sv
`timescale 1ns/1ps
// Directed testbench for waveform_capture: ramp/square/constant captures,
// readout stalls, divided sample rate, mid-capture reset and ignored arms.
module tb_waveform_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 128;
  localparam int PW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] sample_in = '0;
  logic          arm, arm4;
  logic [DW-1:0] trig_level;
  logic          trig_rising;
  logic          rd_ready, rd_ready4;

  logic          busy, done, rd_valid, rd_last, period_valid;
  logic [DW-1:0] rd_data;
  logic [PW-1:0] period;
  logic          busy4, done4, rd_valid4, rd_last4, period_valid4;
  logic [DW-1:0] rd_data4;
  logic [PW-1:0] period4;

  int checks = 0;
  int errors = 0;

  // Stimulus source: 0 = constant, 1 = ramp 0..119, 2 = square 0/128 half-period 60
  int mode = 0;
  int const_val = 0;
  int ph = 0;

  // Readout capture results
  logic [DW-1:0] got [DEPTH];
  int n_xfer, n_last_ok, n_last_bad, n_stall_bad, n_done, timed_out;
  logic busy_after, valid_after;

  always #5 clk = ~clk;

  waveform_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SAMPLE_DIV(1), .PERIOD_WIDTH(PW)) dut (
    .ref_clk(clk), .rst_n(rst_n), .sample_in(sample_in), .arm(arm),
    .trig_level(trig_level), .trig_rising(trig_rising), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .period(period), .period_valid(period_valid)
  );

  waveform_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SAMPLE_DIV(4), .PERIOD_WIDTH(PW)) dut4 (
    .ref_clk(clk), .rst_n(rst_n), .sample_in(sample_in), .arm(arm4),
    .trig_level(trig_level), .trig_rising(trig_rising), .busy(busy4), .done(done4),
    .rd_valid(rd_valid4), .rd_ready(rd_ready4), .rd_data(rd_data4), .rd_last(rd_last4),
    .period(period4), .period_valid(period_valid4)
  );

  // Waveform generator, advancing one step per clock
  always @(posedge clk) begin
    ph <= (ph == 119) ? 0 : ph + 1;
    case (mode)
      0:       sample_in <= const_val[DW-1:0];
      1:       sample_in <= ph[DW-1:0];
      default: sample_in <= (ph < 60) ? 8'd0 : 8'd128;
    endcase
  end

  task automatic wait_ph0();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ph == 0) break;
    end
  endtask

  task automatic arm_dut(input logic [DW-1:0] lvl, input logic rising);
    @(negedge clk);
    arm = 1'b1;
    trig_level = lvl;
    trig_rising = rising;
  endtask

  // Drains one capture from the SAMPLE_DIV=1 instance; pattern 1 = ready 1,0,0,1
  task automatic collect(input int pattern, input bit poke_arm);
    bit prev_stall, finished;
    logic [DW-1:0] pd;
    logic pl;
    int post;
    n_xfer = 0; n_last_ok = 0; n_last_bad = 0; n_stall_bad = 0; n_done = 0;
    timed_out = 0; prev_stall = 0; finished = 0; post = 0; pd = '0; pl = 1'b0;
    busy_after = 1'b1; valid_after = 1'b1;
    for (int cyc = 0; cyc < 3000 && post < 4; cyc++) begin
      @(negedge clk);
      if (done) n_done++;
      if (finished) post++;
      if (prev_stall && ((rd_data !== pd) || (rd_last !== pl))) n_stall_bad++;
      arm = 1'b0;
      rd_ready = (pattern == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (poke_arm && rd_valid && n_xfer == 5) begin
        arm = 1'b1;
        trig_level = 8'd20;
      end
      if (rd_valid && rd_ready) begin
        if (n_xfer < DEPTH) got[n_xfer] = rd_data;
        if (rd_last) begin
          if (n_xfer == DEPTH - 1) n_last_ok++;
          else n_last_bad++;
        end
        n_xfer++;
      end
      if (done && !finished) begin
        finished = 1;
        busy_after = busy;
        valid_after = rd_valid;
      end
      prev_stall = rd_valid && !rd_ready;
      pd = rd_data;
      pl = rd_last;
    end
    if (!finished) timed_out = 1;
    arm = 1'b0;
    rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %0b want 0", rd_last); end
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period got %0d want 0", period); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_period_valid got %0b want 0", period_valid); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %0b want 0", busy4); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    mode = 1;
    wait_ph0();
    arm_dut(8'd60, 1'b1);
    collect(0, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL ramp_timeout got %0d want 0", timed_out); end
    checks++; if (n_xfer !== DEPTH) begin errors++; $display("FAIL ramp_count got %0d want %0d", n_xfer, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== 8'((60 + i) % 120)) begin
        errors++; $display("FAIL ramp_word[%0d] got %0d want %0d", i, got[i], (60 + i) % 120);
      end
    end
    checks++; if (n_last_ok !== 1 || n_last_bad !== 0) begin errors++; $display("FAIL ramp_last got ok=%0d bad=%0d want ok=1 bad=0", n_last_ok, n_last_bad); end
    checks++; if (period !== 16'd120) begin errors++; $display("FAIL ramp_period got %0d want 120", period); end
    checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL ramp_period_valid got %0b want 1", period_valid); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL ramp_done_pulses got %0d want 1", n_done); end
    checks++; if (busy_after !== 1'b0 || valid_after !== 1'b0) begin errors++; $display("FAIL ramp_done_cycle got busy=%0b valid=%0b want 0 0", busy_after, valid_after); end
  endtask

  task automatic test_square();
    logic [DW-1:0] exp_w;
    mode = 2;
    arm_dut(8'd64, 1'b0);
    collect(0, 0);
    checks++; if (n_xfer !== DEPTH) begin errors++; $display("FAIL square_count got %0d want %0d", n_xfer, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      exp_w = (i >= 60 && i < 120) ? 8'd128 : 8'd0;
      checks++;
      if (got[i] !== exp_w) begin
        errors++; $display("FAIL square_word[%0d] got %0d want %0d", i, got[i], exp_w);
      end
    end
    checks++; if (period !== 16'd120) begin errors++; $display("FAIL square_period got %0d want 120", period); end
    checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL square_period_valid got %0b want 1", period_valid); end
  endtask

  task automatic test_stall();
    mode = 1;
    wait_ph0();
    arm_dut(8'd60, 1'b1);
    collect(1, 0);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL stall_timeout got %0d want 0", timed_out); end
    checks++; if (n_stall_bad !== 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", n_stall_bad); end
    checks++; if (n_xfer !== DEPTH) begin errors++; $display("FAIL stall_count got %0d want %0d", n_xfer, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== 8'((60 + i) % 120)) begin
        errors++; $display("FAIL stall_word[%0d] got %0d want %0d", i, got[i], (60 + i) % 120);
      end
    end
    checks++; if (n_last_ok !== 1 || n_last_bad !== 0) begin errors++; $display("FAIL stall_last got ok=%0d bad=%0d want ok=1 bad=0", n_last_ok, n_last_bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL stall_done_pulses got %0d want 1", n_done); end
  endtask

  task automatic test_div4();
    logic [DW-1:0] g4 [DEPTH];
    int n4, step;
    bit fin;
    n4 = 0; fin = 0;
    mode = 1;
    rd_ready4 = 1'b1;
    @(negedge clk);
    arm4 = 1'b1; trig_level = 8'd60; trig_rising = 1'b1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      arm4 = 1'b0;
      if (done4) fin = 1;
      if (rd_valid4 && rd_ready4) begin
        if (n4 < DEPTH) g4[n4] = rd_data4;
        n4++;
      end
    end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL div4_timeout got done=%0b want 1", fin); end
    checks++; if (n4 !== DEPTH) begin errors++; $display("FAIL div4_count got %0d want %0d", n4, DEPTH); end
    checks++; if (g4[0] < 8'd60 || g4[0] > 8'd63) begin errors++; $display("FAIL div4_word0 got %0d want 60..63", g4[0]); end
    for (int i = 1; i < DEPTH; i++) begin
      step = (int'(g4[i]) - int'(g4[i-1]) + 120) % 120;
      checks++;
      if (step !== 4) begin errors++; $display("FAIL div4_step[%0d] got %0d want 4", i, step); end
    end
    checks++; if (period4 !== 16'd30) begin errors++; $display("FAIL div4_period got %0d want 30", period4); end
    checks++; if (period_valid4 !== 1'b1) begin errors++; $display("FAIL div4_period_valid got %0b want 1", period_valid4); end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    wait_ph0();
    arm_dut(8'd60, 1'b1);
    @(negedge clk);
    arm = 1'b0;
    repeat (112) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %0b want 1", busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_before got %0b want 0", rd_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", rd_valid); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL midrst_period_valid got %0b want 0", period_valid); end
    wait_ph0();
    arm_dut(8'd60, 1'b1);
    collect(0, 0);
    checks++; if (n_xfer !== DEPTH) begin errors++; $display("FAIL midrst_count got %0d want %0d", n_xfer, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== 8'((60 + i) % 120)) begin
        errors++; $display("FAIL midrst_word[%0d] got %0d want %0d", i, got[i], (60 + i) % 120);
      end
    end
    checks++; if (period !== 16'd120) begin errors++; $display("FAIL midrst_period got %0d want 120", period); end
  endtask

  task automatic test_arm_ignore();
    mode = 1;
    wait_ph0();
    arm_dut(8'd60, 1'b1);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_armed_busy got %0b want 1", busy); end
    arm = 1'b1; trig_level = 8'd20; trig_rising = 1'b0;
    collect(0, 1);
    checks++; if (timed_out !== 0) begin errors++; $display("FAIL ign_timeout got %0d want 0", timed_out); end
    checks++; if (n_xfer !== DEPTH) begin errors++; $display("FAIL ign_count got %0d want %0d", n_xfer, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== 8'((60 + i) % 120)) begin
        errors++; $display("FAIL ign_word[%0d] got %0d want %0d", i, got[i], (60 + i) % 120);
      end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_after got busy=%0b want 0", busy); end
  endtask

  task automatic test_const();
    mode = 0;
    const_val = 10;
    repeat (4) @(negedge clk);
    arm_dut(8'd60, 1'b1);
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (i % 100 == 99) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL const_busy@%0d got %0b want 1", i, busy); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL const_valid@%0d got %0b want 0", i, rd_valid); end
      end
    end
    const_val = 200;
    collect(0, 0);
    checks++; if (n_xfer !== DEPTH) begin errors++; $display("FAIL const_count got %0d want %0d", n_xfer, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== 8'd200) begin errors++; $display("FAIL const_word[%0d] got %0d want 200", i, got[i]); end
    end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL const_period_valid got %0b want 0", period_valid); end
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL const_period got %0d want 0", period); end
  endtask

  initial begin
    rst_n = 1'b0;
    arm = 1'b0;
    arm4 = 1'b0;
    rd_ready = 1'b1;
    rd_ready4 = 1'b1;
    trig_level = '0;
    trig_rising = 1'b1;
    test_reset();
    test_ramp();
    test_square();
    test_stall();
    test_div4();
    test_reset_mid();
    test_arm_ignore();
    test_const();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
